sync_fifo_flags: RTL and testbench

Parametrised synchronous FIFO, the successor to the basic single-clock FIFO. Adds exact fill count, programmable almost-full/almost-empty thresholds, registered overflow/underflow error pulses, correct operation at any depth (not only powers of two), and a selectable first-word-fall-through (FWFT) read mode. Used as the general buffering element between streaming stages in one clock domain.

---
 rtl/sync_fifo_flags_pkg.sv | 15 +
 rtl/sync_fifo_flags_ram.sv | 24 ++
 rtl/sync_fifo_flags.sv | 120 ++++++++++++
 tb/tb_sync_fifo_flags.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_flags_pkg.sv
// Shared constants and width helpers for the flagged synchronous FIFO.
package sync_fifo_flags_pkg;

  localparam int FWFT_STD = 0;
  localparam int FWFT_ON  = 1;

  function automatic int ptr_w(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sync_fifo_flags_ram.sv
// Simple dual-port RAM with registered read; read-before-write on address collision.
module sync_fifo_flags_ram #(
  parameter int DATA_WIDTH = 36,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with exact count, threshold flags, error pulses, any depth and optional FWFT.
module sync_fifo_flags
  import sync_fifo_flags_pkg::*;
#(
  parameter int DATA_WIDTH = 36,
  parameter int FIFO_DEPTH = 1024,
  parameter int FWFT       = 0,
  parameter int AF_THRESH  = FIFO_DEPTH - 2,
  parameter int AE_THRESH  = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ce,
  input  logic                          we,
  input  logic [DATA_WIDTH-1:0]         din,
  input  logic                          oe,
  output logic [DATA_WIDTH-1:0]         dout,
  output logic                          valid,
  output logic                          full,
  output logic                          almost_full,
  output logic                          empty,
  output logic                          almost_empty,
  output logic [cnt_w(FIFO_DEPTH)-1:0]  count,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int PW = ptr_w(FIFO_DEPTH);
  localparam int CW = cnt_w(FIFO_DEPTH);

  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic                  wr_acc, rd_acc, can_rd, ram_ren;
  logic [DATA_WIDTH-1:0] rdata;

  // Pointers wrap at FIFO_DEPTH-1 so non power-of-two depths use every entry.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign rd_acc       = ce & oe & can_rd;
  assign wr_acc       = ce & we & (~full | rd_acc);
  assign full         = (count == CW'(FIFO_DEPTH));
  assign almost_full  = (int'(count) >= AF_THRESH);
  assign almost_empty = (int'(count) <= AE_THRESH);

  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= ce & we & ~wr_acc;
      underflow <= ce & oe & ~rd_acc;
      if (wr_acc)  wr_ptr <= ptr_inc(wr_ptr);
      if (ram_ren) rd_ptr <= ptr_inc(rd_ptr);
      if (wr_acc & ~rd_acc)      count <= count + CW'(1);
      else if (~wr_acc & rd_acc) count <= count - CW'(1);
    end
  end

  sync_fifo_flags_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (PW)
  ) ram_inst (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc & ~rst),
    .waddr (wr_ptr),
    .wdata (din),
    .re    (ram_ren),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  if (FWFT == FWFT_ON) begin : g_fwft
    logic                  vld_p1, valid_p2, out_load;
    logic [DATA_WIDTH-1:0] dout_p2;
    logic [CW-1:0]         ram_cnt;

    // Words still in RAM: count also covers the RAM output (p1) and dout (p2) stages.
    assign ram_cnt  = count - CW'(vld_p1) - CW'(valid_p2);
    assign out_load = ~valid_p2 | rd_acc;
    assign ram_ren  = ce & (ram_cnt != '0) & (~vld_p1 | out_load);
    assign can_rd   = valid_p2;

    // p1: RAM output register / p2: dout register
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_p1   <= 1'b0;
        valid_p2 <= 1'b0;
        dout_p2  <= '0;
      end else if (ce) begin
        vld_p1   <= ram_ren | (vld_p1 & ~out_load);
        valid_p2 <= (vld_p1 & out_load) | (valid_p2 & ~rd_acc);
        if (vld_p1 & out_load) dout_p2 <= rdata;
      end
    end

    assign valid = valid_p2;
    assign dout  = dout_p2;
    assign empty = ~valid_p2;
  end else begin : g_std
    logic valid_p1;

    assign ram_ren = rd_acc;
    assign can_rd  = (count != '0);

    always_ff @(posedge clk) begin
      if (rst)     valid_p1 <= 1'b0;
      else if (ce) valid_p1 <= rd_acc;
    end

    assign valid = valid_p1;
    assign dout  = rdata;
    assign empty = (count == '0);
  end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench: a DEPTH=5 standard-mode FIFO and a DEPTH=4 FWFT FIFO on one clock.
module tb_sync_fifo_flags;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic       a_rst, a_ce, a_we, a_oe;
  logic [7:0] a_din, a_dout;
  logic       a_valid, a_full, a_af, a_empty, a_ae, a_ovf, a_unf;
  logic [2:0] a_count;

  logic       b_rst, b_ce, b_we, b_oe;
  logic [7:0] b_din, b_dout;
  logic       b_valid, b_full, b_af, b_empty, b_ae, b_ovf, b_unf;
  logic [2:0] b_count;

  sync_fifo_flags #(
    .DATA_WIDTH (8), .FIFO_DEPTH (5), .FWFT (0), .AF_THRESH (3), .AE_THRESH (1)
  ) dut_a (
    .clk (clk), .rst (a_rst), .ce (a_ce), .we (a_we), .din (a_din), .oe (a_oe),
    .dout (a_dout), .valid (a_valid), .full (a_full), .almost_full (a_af),
    .empty (a_empty), .almost_empty (a_ae), .count (a_count),
    .overflow (a_ovf), .underflow (a_unf)
  );

  sync_fifo_flags #(
    .DATA_WIDTH (8), .FIFO_DEPTH (4), .FWFT (1)
  ) dut_b (
    .clk (clk), .rst (b_rst), .ce (b_ce), .we (b_we), .din (b_din), .oe (b_oe),
    .dout (b_dout), .valid (b_valid), .full (b_full), .almost_full (b_af),
    .empty (b_empty), .almost_empty (b_ae), .count (b_count),
    .overflow (b_ovf), .underflow (b_unf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_set(input logic w, input logic r, input logic [7:0] d);
    a_we  = w;
    a_oe  = r;
    a_din = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    a_rst = 1'b1; a_ce = 1'b1; a_set(1'b0, 1'b0, 8'h00);
    b_rst = 1'b1; b_ce = 1'b1; b_we = 1'b0; b_oe = 1'b0; b_din = 8'h00;
    tick();
    tick();

    chk("a_rst_count", 32'(a_count), 0);
    chk("a_rst_empty", 32'(a_empty), 1);
    chk("a_rst_ae",    32'(a_ae),    1);
    chk("a_rst_full",  32'(a_full),  0);
    chk("a_rst_af",    32'(a_af),    0);
    chk("a_rst_valid", 32'(a_valid), 0);
    chk("a_rst_dout",  32'(a_dout),  0);
    chk("a_rst_ovf",   32'(a_ovf),   0);
    chk("a_rst_unf",   32'(a_unf),   0);
    chk("b_rst_count", 32'(b_count), 0);
    chk("b_rst_empty", 32'(b_empty), 1);
    chk("b_rst_valid", 32'(b_valid), 0);
    chk("b_rst_dout",  32'(b_dout),  0);
    a_rst = 1'b0;
    b_rst = 1'b0;

    // Fill 1..5 with threshold flags at AE=1, AF=3
    for (int i = 1; i <= 5; i++) begin
      a_set(1'b1, 1'b0, 8'(i));
      tick();
      chk("fill_count", 32'(a_count), 32'(i));
      chk("fill_full",  32'(a_full),  (i == 5) ? 1 : 0);
      chk("fill_ae",    32'(a_ae),    (i <= 1) ? 1 : 0);
      chk("fill_af",    32'(a_af),    (i >= 3) ? 1 : 0);
      chk("fill_empty", 32'(a_empty), 0);
      chk("fill_ovf",   32'(a_ovf),   0);
    end
    a_set(1'b1, 1'b0, 8'hAA);
    tick();
    chk("ovf_pulse", 32'(a_ovf),   1);
    chk("ovf_count", 32'(a_count), 5);
    chk("ovf_full",  32'(a_full),  1);
    a_set(1'b0, 1'b0, 8'h00);
    tick();
    chk("ovf_clear", 32'(a_ovf),   0);
    chk("ovf_hold",  32'(a_count), 5);

    for (int j = 1; j <= 5; j++) begin
      a_set(1'b0, 1'b1, 8'h00);
      tick();
      chk("rd_valid", 32'(a_valid), 1);
      chk("rd_dout",  32'(a_dout),  32'(j));
      chk("rd_count", 32'(a_count), 32'(5 - j));
    end
    chk("drain_empty", 32'(a_empty), 1);
    a_set(1'b0, 1'b0, 8'h00);
    tick();
    chk("idle_valid", 32'(a_valid), 0);
    chk("idle_dout",  32'(a_dout),  5);
    a_set(1'b0, 1'b1, 8'h00);
    tick();
    chk("unf_pulse", 32'(a_unf),   1);
    chk("unf_valid", 32'(a_valid), 0);
    chk("unf_count", 32'(a_count), 0);
    a_set(1'b0, 1'b0, 8'h00);
    tick();
    chk("unf_clear", 32'(a_unf), 0);

    // Interleaved traffic crossing the pointer wrap several times
    for (int k = 0; k < 3; k++) begin
      a_set(1'b1, 1'b0, 8'(8'h10 + k));
      tick();
      chk("pre_count", 32'(a_count), 32'(k + 1));
    end
    for (int k = 0; k < 12; k++) begin
      a_set(1'b1, 1'b1, 8'(8'h13 + k));
      tick();
      chk("il_valid", 32'(a_valid), 1);
      chk("il_dout",  32'(a_dout),  32'(8'h10 + k));
      chk("il_count", 32'(a_count), 3);
      chk("il_full",  32'(a_full),  0);
      chk("il_empty", 32'(a_empty), 0);
    end
    for (int k = 0; k < 3; k++) begin
      a_set(1'b0, 1'b1, 8'h00);
      tick();
      chk("il_drain_dout",  32'(a_dout),  32'(8'h1C + k));
      chk("il_drain_count", 32'(a_count), 32'(2 - k));
    end

    // Full with same-cycle read and write, then empty with same-cycle read and write
    for (int k = 0; k < 5; k++) begin
      a_set(1'b1, 1'b0, 8'(8'h20 + k));
      tick();
    end
    chk("fw_full", 32'(a_full), 1);
    a_set(1'b1, 1'b1, 8'h25);
    tick();
    chk("fw_count", 32'(a_count), 5);
    chk("fw_ovf",   32'(a_ovf),   0);
    chk("fw_full2", 32'(a_full),  1);
    chk("fw_valid", 32'(a_valid), 1);
    chk("fw_dout",  32'(a_dout),  8'h20);
    for (int k = 0; k < 5; k++) begin
      a_set(1'b0, 1'b1, 8'h00);
      tick();
      chk("fw_drain", 32'(a_dout), 32'(8'h21 + k));
    end
    chk("fw_empty", 32'(a_empty), 1);
    a_set(1'b1, 1'b1, 8'h30);
    tick();
    chk("ew_unf",   32'(a_unf),   1);
    chk("ew_count", 32'(a_count), 1);
    chk("ew_valid", 32'(a_valid), 0);
    chk("ew_empty", 32'(a_empty), 0);
    a_set(1'b0, 1'b1, 8'h00);
    tick();
    chk("ew_dout",  32'(a_dout),  8'h30);
    chk("ew_rcnt",  32'(a_count), 0);
    chk("ew_unf2",  32'(a_unf),   0);

    // Reset with ce low discards contents; ce low freezes everything
    for (int k = 0; k < 3; k++) begin
      a_set(1'b1, 1'b0, 8'(8'h40 + k));
      tick();
    end
    chk("pr_count", 32'(a_count), 3);
    a_set(1'b0, 1'b0, 8'h00);
    a_rst = 1'b1;
    a_ce  = 1'b0;
    tick();
    a_rst = 1'b0;
    chk("rce_count", 32'(a_count), 0);
    chk("rce_empty", 32'(a_empty), 1);
    chk("rce_valid", 32'(a_valid), 0);
    chk("rce_dout",  32'(a_dout),  0);
    for (int k = 0; k < 4; k++) begin
      a_set(k[0], ~k[0] | k[1], 8'h77);
      tick();
      chk("ce0_count", 32'(a_count), 0);
      chk("ce0_ovf",   32'(a_ovf),   0);
      chk("ce0_unf",   32'(a_unf),   0);
      chk("ce0_valid", 32'(a_valid), 0);
    end
    a_ce = 1'b1;
    a_set(1'b1, 1'b0, 8'h50);
    tick();
    a_set(1'b0, 1'b1, 8'h00);
    tick();
    chk("post_rst_dout",  32'(a_dout),  8'h50);
    chk("post_rst_valid", 32'(a_valid), 1);
    a_set(1'b0, 1'b0, 8'h00);

    // FWFT: single word appears two edges after the write with no read request
    b_we = 1'b1; b_din = 8'h3C;
    tick();
    b_we = 1'b0;
    chk("fwft_n0_count", 32'(b_count), 1);
    chk("fwft_n0_valid", 32'(b_valid), 0);
    chk("fwft_n0_empty", 32'(b_empty), 1);
    tick();
    chk("fwft_n1_valid", 32'(b_valid), 0);
    tick();
    chk("fwft_n2_valid", 32'(b_valid), 1);
    chk("fwft_n2_dout",  32'(b_dout),  8'h3C);
    chk("fwft_n2_empty", 32'(b_empty), 0);
    b_oe = 1'b1;
    tick();
    b_oe = 1'b0;
    chk("fwft_pop_valid", 32'(b_valid), 0);
    chk("fwft_pop_empty", 32'(b_empty), 1);
    chk("fwft_pop_count", 32'(b_count), 0);
    chk("fwft_pop_unf",   32'(b_unf),   0);

    // FWFT: fill to depth, reject extra write, drain in order
    for (int i = 1; i <= 4; i++) begin
      b_we = 1'b1; b_din = 8'(i);
      tick();
    end
    b_din = 8'h99;
    tick();
    b_we = 1'b0;
    chk("fwft_ovf",   32'(b_ovf),   1);
    chk("fwft_fcnt",  32'(b_count), 4);
    chk("fwft_full",  32'(b_full),  1);
    tick();
    chk("fwft_head_valid", 32'(b_valid), 1);
    chk("fwft_head_dout",  32'(b_dout),  1);
    chk("fwft_ovf_clear",  32'(b_ovf),   0);
    for (int k = 1; k <= 3; k++) begin
      b_oe = 1'b1;
      tick();
      chk("fwft_drain_dout",  32'(b_dout),  32'(1 + k));
      chk("fwft_drain_valid", 32'(b_valid), 1);
      chk("fwft_drain_count", 32'(b_count), 32'(4 - k));
    end
    tick();
    b_oe = 1'b0;
    chk("fwft_last_valid", 32'(b_valid), 0);
    chk("fwft_last_empty", 32'(b_empty), 1);
    chk("fwft_last_count", 32'(b_count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
